// File: rtl/rgen_host_if_apb.sv
// APB4 slave front end: turns each APB transfer into one internal register command
// and returns the register block's read data / status as PRDATA / PSLVERR.
module rgen_host_if_apb #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TIMEOUT       = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic                      i_pwrite,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
  output logic                      o_pready,
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pslverr,
  output logic                      o_command_valid,
  output logic                      o_write,
  output logic [ADDRESS_WIDTH-1:0]  o_address,
  output logic [DATA_WIDTH-1:0]     o_write_data,
  output logic [DATA_WIDTH-1:0]     o_write_mask,
  input  logic                      i_response_ready,
  input  logic [DATA_WIDTH-1:0]     i_read_data,
  input  logic                      i_status
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_cmd_valid, w_cmd_valid_nxt;
  logic                       r_write, w_write_nxt;
  logic [ADDRESS_WIDTH-1:0]   r_address, w_address_nxt;
  logic [DATA_WIDTH-1:0]      r_wdata, w_wdata_nxt;
  logic [DATA_WIDTH-1:0]      r_wmask, w_wmask_nxt;
  logic                       r_pready, w_pready_nxt;
  logic [DATA_WIDTH-1:0]      r_prdata, w_prdata_nxt;
  logic                       r_pslverr, w_pslverr_nxt;
  logic [CNT_W-1:0]           r_count, w_count_nxt;
  logic                       r_abort, w_abort_nxt;
  logic                       w_expired;

  assign w_expired = (TIMEOUT != 0) && (r_count == CNT_LAST);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_write     <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_pready    <= 1'b0;
      r_prdata    <= '0;
      r_pslverr   <= 1'b0;
      r_count     <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_write     <= w_write_nxt;
      r_address   <= w_address_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wmask     <= w_wmask_nxt;
      r_pready    <= w_pready_nxt;
      r_prdata    <= w_prdata_nxt;
      r_pslverr   <= w_pslverr_nxt;
      r_count     <= w_count_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  // Next state and next output values
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_valid_nxt = 1'b0;
    w_write_nxt     = r_write;
    w_address_nxt   = r_address;
    w_wdata_nxt     = r_wdata;
    w_wmask_nxt     = r_wmask;
    w_pready_nxt    = 1'b0;
    w_prdata_nxt    = '0;
    w_pslverr_nxt   = 1'b0;
    w_count_nxt     = '0;
    w_abort_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_psel && !i_penable) begin
          w_state_nxt     = ST_BUSY;
          w_cmd_valid_nxt = 1'b1;
          w_write_nxt     = i_pwrite;
          w_address_nxt   = i_paddr;
          w_wdata_nxt     = i_pwdata;
          for (int unsigned b = 0; b < STRB_W; b++) begin
            w_wmask_nxt[8*b +: 8] = i_pwrite ? {8{i_pstrb[b]}} : 8'hFF;
          end
        end
      end

      ST_BUSY: begin
        // Once the master abandons the transfer, finish internally but never answer
        w_abort_nxt = r_abort || !i_psel;
        if (i_response_ready) begin
          if (w_abort_nxt) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt   = ST_RESPOND;
            w_pready_nxt  = 1'b1;
            w_prdata_nxt  = r_write ? '0 : i_read_data;
            w_pslverr_nxt = i_status;
          end
          w_abort_nxt = 1'b0;
        end else if (w_expired) begin
          if (w_abort_nxt) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt   = ST_RESPOND;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
          end
          w_abort_nxt = 1'b0;
        end else begin
          w_cmd_valid_nxt = 1'b1;
          if (TIMEOUT != 0) begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end

      ST_RESPOND: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_pready        = r_pready;
  assign o_prdata        = r_prdata;
  assign o_pslverr       = r_pslverr;
  assign o_command_valid = r_cmd_valid;
  assign o_write         = r_write;
  assign o_address       = r_address;
  assign o_write_data    = r_wdata;
  assign o_write_mask    = r_wmask;

endmodule

// File: tb/tb_rgen_host_if_apb.sv
// Self-checking bench for rgen_host_if_apb: directed cases plus randomized transfers
// checked against a transfer-level model (latency, mask, response/timeout outcome).
module tb_rgen_host_if_apb;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;

  logic          clk, rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;
  logic          cmd_valid, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, cmd_wmask;
  logic          resp_ready, status;
  logic [DW-1:0] rdata;

  int errors = 0;
  int checks = 0;

  rgen_host_if_apb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_psel(psel), .i_penable(penable), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
    .o_command_valid(cmd_valid), .o_write(cmd_write), .o_address(cmd_addr),
    .o_write_data(cmd_wdata), .o_write_mask(cmd_wmask),
    .i_response_ready(resp_ready), .i_read_data(rdata), .i_status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One APB transfer. delay = BUSY cycle (1-based) carrying the response, 0 = never.
  // drop = master releases psel in the first BUSY cycle.
  task automatic xfer(input string name, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [3:0] strb, input int delay,
                      input logic [DW-1:0] rd, input logic st, input logic drop);
    logic [DW-1:0] exp_mask, exp_rdata;
    logic          exp_err, responded;
    int            n_busy;
    exp_mask = '1;
    if (wr) for (int b = 0; b < 4; b++) exp_mask[8*b +: 8] = strb[b] ? 8'hFF : 8'h00;
    responded = (delay >= 1) && (delay <= int'(TMO));
    n_busy    = responded ? delay : int'(TMO);
    exp_rdata = (responded && !wr) ? rd : '0;
    exp_err   = responded ? st : 1'b1;

    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = strb;
    @(posedge clk); #1;
    checks++;
    if ({cmd_write, cmd_addr, cmd_wdata} !== {wr, addr, wd}) begin
      errors++;
      $display("FAIL %s cmd_fields: got w=%b a=%h d=%h expected w=%b a=%h d=%h",
               name, cmd_write, cmd_addr, cmd_wdata, wr, addr, wd);
    end
    checks++;
    if (cmd_wmask !== exp_mask) begin
      errors++;
      $display("FAIL %s write_mask: got %h expected %h", name, cmd_wmask, exp_mask);
    end

    for (int k = 1; k <= n_busy; k++) begin
      checks++;
      if ({cmd_valid, pready, cmd_addr} !== {1'b1, 1'b0, addr}) begin
        errors++;
        $display("FAIL %s busy_cycle%0d: got valid=%b pready=%b addr=%h expected 1 0 %h",
                 name, k, cmd_valid, pready, cmd_addr, addr);
      end
      @(negedge clk);
      penable = 1'b1;
      if (drop) begin psel = 1'b0; penable = 1'b0; end
      resp_ready = (k == delay);
      rdata  = (k == delay) ? rd : $urandom;
      status = (k == delay) ? st : 1'($urandom);
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end

    if (drop) begin
      checks++;
      if ({cmd_valid, pready} !== 2'b00) begin
        errors++;
        $display("FAIL %s dropped_end: got valid=%b pready=%b expected 0 0", name, cmd_valid, pready);
      end
    end else begin
      checks++;
      if ({cmd_valid, pready, pslverr, prdata} !== {1'b0, 1'b1, exp_err, exp_rdata}) begin
        errors++;
        $display("FAIL %s respond: got valid=%b pready=%b err=%b rdata=%h expected 0 1 %b %h",
                 name, cmd_valid, pready, pslverr, prdata, exp_err, exp_rdata);
      end
      @(negedge clk);
      @(posedge clk); #1;
      checks++;
      if ({pready, pslverr, prdata} !== {1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL %s back_to_idle: got pready=%b err=%b rdata=%h expected 0 0 0",
                 name, pready, pslverr, prdata);
      end
    end
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    psel = 0; penable = 0; paddr = '0; pwrite = 0; pwdata = '0; pstrb = '0;
    resp_ready = 0; rdata = '0; status = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pready, pslverr, prdata, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_state: got pready=%b valid=%b addr=%h mask=%h expected all zero",
               pready, cmd_valid, cmd_addr, cmd_wmask);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    xfer("wr_full",    1'b1, 16'h0010, 32'hDEADBEEF, 4'b1111, 2, 32'h0, 1'b0, 1'b0);
    xfer("rd_fast",    1'b0, 16'h0004, 32'h0,        4'b0000, 1, 32'h12345678, 1'b0, 1'b0);
    xfer("wr_strb",    1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 1'b0, 1'b0);
    xfer("rd_status",  1'b0, 16'h0008, 32'h0,        4'b0000, 3, 32'hCAFEF00D, 1'b1, 1'b0);
    bus_idle(2);
  endtask

  task automatic test_timeout();
    xfer("tmo_none",   1'b0, 16'h0100, 32'h0, 4'b0000, 0, 32'h55AA55AA, 1'b0, 1'b0);
    xfer("tmo_edge",   1'b0, 16'h0104, 32'h0, 4'b0000, 4, 32'h0BADCAFE, 1'b0, 1'b0);
    xfer("tmo_wr",     1'b1, 16'h0108, 32'h11223344, 4'b1000, 0, 32'h0, 1'b0, 1'b0);
    bus_idle(1);
  endtask

  task automatic test_protocol();
    xfer("psel_drop",  1'b1, 16'h0200, 32'h01020304, 4'b0011, 2, 32'h0, 1'b0, 1'b1);
    xfer("drop_tmo",   1'b0, 16'h0204, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b1);
    // psel+penable in IDLE and a stray response must both be ignored
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; resp_ready = 1'b1; rdata = 32'hFFFFFFFF; status = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cmd_valid, pready, pslverr, prdata} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL idle_ignore: got valid=%b pready=%b err=%b rdata=%h expected 0 0 0 0",
               cmd_valid, pready, pslverr, prdata);
    end
    bus_idle(1);
    xfer("after_prot", 1'b0, 16'h0208, 32'h0, 4'b0000, 1, 32'h600DD00D, 1'b0, 1'b0);
    bus_idle(1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = 16'h0300; pwrite = 1'b1; pwdata = 32'h77777777; pstrb = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pready, pslverr, prdata, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b addr=%h data=%h mask=%h expected all zero",
               cmd_valid, cmd_addr, cmd_wdata, cmd_wmask);
    end
    @(negedge clk);
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    xfer("after_rst",  1'b1, 16'h0304, 32'h89ABCDEF, 4'b1100, 2, 32'h0, 1'b0, 1'b0);
    bus_idle(1);
  endtask

  task automatic test_back_to_back();
    xfer("b2b_0", 1'b1, 16'h0400, 32'h00000001, 4'b0001, 1, 32'h0, 1'b0, 1'b0);
    xfer("b2b_1", 1'b0, 16'h0404, 32'h0, 4'b0000, 1, 32'hA5A5A5A5, 1'b0, 1'b0);
    xfer("b2b_2", 1'b0, 16'h0408, 32'h0, 4'b0000, 2, 32'h5A5A5A5A, 1'b1, 1'b0);
    bus_idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      xfer($sformatf("rand%0d", i), 1'($urandom), AW'($urandom), $urandom, 4'($urandom),
           int'($urandom_range(0, 6)), $urandom, 1'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) bus_idle(int'($urandom_range(1, 2)));
    end
    bus_idle(1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_protocol();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
